// File: rtl/rvfpm_pkg.sv
// Shared opcodes and issue-entry layout for the rvfpm front end.
package rvfpm_pkg;

  localparam logic [6:0] OPC_LOAD_FP  = 7'b0000111;
  localparam logic [6:0] OPC_STORE_FP = 7'b0100111;
  localparam logic [6:0] OPC_FMADD    = 7'b1000011;
  localparam logic [6:0] OPC_FMSUB    = 7'b1000111;
  localparam logic [6:0] OPC_FNMSUB   = 7'b1001011;
  localparam logic [6:0] OPC_FNMADD   = 7'b1001111;
  localparam logic [6:0] OPC_OP_FP    = 7'b1010011;

  localparam int unsigned ENTRY_ID_W = 4;
  localparam int unsigned ENTRY_XLEN = 32;

  typedef struct packed {
    logic [31:0]             instr;
    logic [ENTRY_ID_W-1:0]   id;
    logic [ENTRY_XLEN-1:0]   rs1;
  } issue_entry_t;

endpackage

// File: rtl/rvfpm_fp_decode.sv
// Major-opcode decode: flags instructions that belong to the F extension.
module rvfpm_fp_decode
  import rvfpm_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       accept
);

  always_comb begin
    accept = 1'b0;
    unique case (opcode)
      OPC_LOAD_FP, OPC_STORE_FP,
      OPC_FMADD, OPC_FMSUB, OPC_FNMSUB, OPC_FNMADD,
      OPC_OP_FP: accept = 1'b1;
      default:   accept = 1'b0;
    endcase
  end

endmodule

// File: rtl/rvfpm_issue_queue.sv
// XIF issue queue feeding the rvfpm core through an enable/fpu_ready handshake.
// Optional same-cycle bypass into an empty queue: define RVFPM_ISSUE_BYPASS_EN.
module rvfpm_issue_queue
  import rvfpm_pkg::*;
#(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned X_ID_WIDTH = ENTRY_ID_W,
  parameter int unsigned XLEN       = ENTRY_XLEN
) (
  input  logic                    ck,
  input  logic                    rst,
  input  logic                    issue_valid,
  output logic                    issue_ready,
  input  logic [31:0]             issue_instr,
  input  logic [X_ID_WIDTH-1:0]   issue_id,
  input  logic [XLEN-1:0]         issue_rs1,
  output logic                    issue_accept,
  input  logic                    flush,
  output logic                    enable,
  input  logic                    fpu_ready,
  output logic [31:0]             instruction,
  output logic [X_ID_WIDTH-1:0]   id,
  output logic [XLEN-1:0]         data_fromXReg,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  issue_entry_t  mem_q [DEPTH];
  issue_entry_t  mem_d [DEPTH];
  issue_entry_t  new_entry, head;
  logic          full, empty, xfer, push, pop, bypass;

  rvfpm_fp_decode u_decode (
    .opcode (issue_instr[6:0]),
    .accept (issue_accept)
  );

  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty = (wr_ptr_q == rd_ptr_q);

  assign issue_ready = !full && !flush;
  assign xfer        = issue_valid && issue_ready;

`ifdef RVFPM_ISSUE_BYPASS_EN
  assign bypass = empty && xfer && issue_accept && fpu_ready;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed request is consumed by the FPU directly and never stored.
  assign push = xfer && issue_accept && !bypass;
  assign pop  = !empty && fpu_ready;

  assign new_entry = '{instr: issue_instr,
                       id:    ENTRY_ID_W'(issue_id),
                       rs1:   ENTRY_XLEN'(issue_rs1)};
  assign head = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[AW-1:0]] = new_entry;
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge ck) begin
    mem_q <= mem_d;
  end

  always_comb begin
    enable        = !empty;
    instruction   = '0;
    id            = '0;
    data_fromXReg = '0;
    if (!empty) begin
      instruction   = head.instr;
      id            = X_ID_WIDTH'(head.id);
      data_fromXReg = XLEN'(head.rs1);
    end
`ifdef RVFPM_ISSUE_BYPASS_EN
    if (bypass) begin
      enable        = 1'b1;
      instruction   = issue_instr;
      id            = issue_id;
      data_fromXReg = issue_rs1;
    end
`endif
  end

  assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: tb/tb_rvfpm_issue_queue.sv
// Directed self-checking bench for rvfpm_issue_queue (DEPTH=4).
module tb_rvfpm_issue_queue;

  logic        ck = 1'b0;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [31:0] issue_instr;
  logic [3:0]  issue_id;
  logic [31:0] issue_rs1;
  logic        issue_accept;
  logic        flush;
  logic        enable;
  logic        fpu_ready;
  logic [31:0] instruction;
  logic [3:0]  id;
  logic [31:0] data_fromXReg;
  logic [2:0]  count;

  int unsigned tests_run = 0;
  int unsigned failures  = 0;

  localparam logic [31:0] FADD = 32'h00C58553;
  localparam logic [31:0] ADD  = 32'h00B50533;

  rvfpm_issue_queue #(.DEPTH(4), .X_ID_WIDTH(4), .XLEN(32)) dut (
    .ck            (ck),
    .rst           (rst),
    .issue_valid   (issue_valid),
    .issue_ready   (issue_ready),
    .issue_instr   (issue_instr),
    .issue_id      (issue_id),
    .issue_rs1     (issue_rs1),
    .issue_accept  (issue_accept),
    .flush         (flush),
    .enable        (enable),
    .fpu_ready     (fpu_ready),
    .instruction   (instruction),
    .id            (id),
    .data_fromXReg (data_fromXReg),
    .count         (count)
  );

  always #5 ck = ~ck;

  task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] i,
                       input logic [31:0] r);
    issue_valid = v;
    issue_instr = ins;
    issue_id    = i;
    issue_rs1   = r;
  endtask

  // Inputs change at the falling edge; checks happen 1 time unit later.
  task automatic half;
    @(negedge ck);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; flush = 1'b0; fpu_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    #12;
    tests_run++;
    if (enable !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL reset_state enable=%b count=%0d required 0/0", enable, count);
    end
    tests_run++;
    if (instruction !== 32'h0 || id !== 4'h0 || data_fromXReg !== 32'h0) begin
      failures++; $display("FAIL reset_head instr=%h id=%h rs1=%h required zeros", instruction, id, data_fromXReg);
    end
    @(negedge ck); rst = 1'b1;
    #1;
    tests_run++;
    if (issue_ready !== 1'b1) begin
      failures++; $display("FAIL reset_ready got=%b required=1", issue_ready);
    end
  endtask

  task automatic test_single;
    half;
    drive(1'b1, FADD, 4'd3, 32'h0);
    #1;
    tests_run++;
    if (issue_accept !== 1'b1 || enable !== 1'b0) begin
      failures++; $display("FAIL single_accept accept=%b enable=%b required 1/0", issue_accept, enable);
    end
    half;
    drive(1'b0, '0, '0, '0);
    tests_run++;
    if (enable !== 1'b1 || instruction !== FADD || id !== 4'd3 || count !== 3'd1) begin
      failures++; $display("FAIL single_dispatch en=%b instr=%h id=%0d count=%0d required 1/%h/3/1",
                           enable, instruction, id, count, FADD);
    end
    fpu_ready = 1'b1;
    half;
    fpu_ready = 1'b0;
    tests_run++;
    if (enable !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL single_pop en=%b count=%0d required 0/0", enable, count);
    end
  endtask

  task automatic test_non_fp;
    half;
    drive(1'b1, ADD, 4'd5, 32'h1234);
    #1;
    tests_run++;
    if (issue_accept !== 1'b0 || issue_ready !== 1'b1) begin
      failures++; $display("FAIL nonfp_accept accept=%b ready=%b required 0/1", issue_accept, issue_ready);
    end
    half;
    drive(1'b0, '0, '0, '0);
    tests_run++;
    if (count !== 3'd0 || enable !== 1'b0) begin
      failures++; $display("FAIL nonfp_store count=%0d en=%b required 0/0", count, enable);
    end
  endtask

  task automatic test_full;
    logic [3:0] exp_id;
    fpu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      half;
      drive(1'b1, FADD, 4'(i), 32'(i * 17));
    end
    half;
    drive(1'b1, FADD, 4'd4, 32'd68);
    tests_run++;
    if (count !== 3'd4 || issue_ready !== 1'b0 || id !== 4'd0) begin
      failures++; $display("FAIL full_level count=%0d ready=%b head=%0d required 4/0/0", count, issue_ready, id);
    end
    half;
    tests_run++;
    if (count !== 3'd4 || id !== 4'd0 || data_fromXReg !== 32'd0) begin
      failures++; $display("FAIL full_hold count=%0d head=%0d rs1=%0d required 4/0/0", count, id, data_fromXReg);
    end
    // Pop while full: no look-ahead, so id 4 is still refused this cycle.
    fpu_ready = 1'b1;
    #1;
    tests_run++;
    if (issue_ready !== 1'b0) begin
      failures++; $display("FAIL full_no_lookahead ready=%b required 0", issue_ready);
    end
    half;
    tests_run++;
    if (count !== 3'd3 || id !== 4'd1 || issue_ready !== 1'b1) begin
      failures++; $display("FAIL full_first_pop count=%0d head=%0d ready=%b required 3/1/1", count, id, issue_ready);
    end
    half;
    drive(1'b0, '0, '0, '0);
    tests_run++;
    if (count !== 3'd3 || id !== 4'd2) begin
      failures++; $display("FAIL full_refill count=%0d head=%0d required 3/2", count, id);
    end
    exp_id = 4'd2;
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if (enable !== 1'b1 || id !== exp_id || data_fromXReg !== 32'(exp_id * 17)) begin
        failures++; $display("FAIL full_drain en=%b id=%0d rs1=%0d required 1/%0d/%0d",
                             enable, id, data_fromXReg, exp_id, exp_id * 17);
      end
      exp_id++;
      half;
    end
    fpu_ready = 1'b0;
    tests_run++;
    if (enable !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL full_empty en=%b count=%0d required 0/0", enable, count);
    end
  endtask

  task automatic test_back_to_back;
    half; drive(1'b1, FADD, 4'd10, 32'hA);
    half; drive(1'b1, FADD, 4'd11, 32'hB);
    half; drive(1'b1, FADD, 4'd7, 32'h7);
    fpu_ready = 1'b1;
    half;
    drive(1'b0, '0, '0, '0);
    fpu_ready = 1'b0;
    tests_run++;
    if (count !== 3'd2 || id !== 4'd11) begin
      failures++; $display("FAIL b2b_pushpop count=%0d head=%0d required 2/11", count, id);
    end
    fpu_ready = 1'b1;
    half;
    tests_run++;
    if (id !== 4'd7 || data_fromXReg !== 32'h7) begin
      failures++; $display("FAIL b2b_second id=%0d rs1=%h required 7/7", id, data_fromXReg);
    end
    half;
    fpu_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL b2b_drain count=%0d required 0", count);
    end
  endtask

  task automatic test_wrap;
    half; drive(1'b1, FADD, 4'd0, 32'h0);
    half;
    fpu_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, FADD, 4'(i + 1), 32'(i + 1));
      tests_run++;
      if (enable !== 1'b1 || id !== 4'(i) || count !== 3'd1) begin
        failures++; $display("FAIL wrap_step%0d id=%0d count=%0d required %0d/1", i, id, count, i);
      end
      half;
    end
    drive(1'b0, '0, '0, '0);
    tests_run++;
    if (id !== 4'd10 || data_fromXReg !== 32'd10) begin
      failures++; $display("FAIL wrap_last id=%0d rs1=%0d required 10/10", id, data_fromXReg);
    end
    half;
    fpu_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0 || enable !== 1'b0) begin
      failures++; $display("FAIL wrap_empty count=%0d en=%b required 0/0", count, enable);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) begin
      half; drive(1'b1, FADD, 4'(i), 32'(i));
    end
    half;
    flush = 1'b1; fpu_ready = 1'b1;
    drive(1'b1, FADD, 4'd12, 32'hC);
    #1;
    tests_run++;
    if (issue_ready !== 1'b0 || count !== 3'd3) begin
      failures++; $display("FAIL flush_ready ready=%b count=%0d required 0/3", issue_ready, count);
    end
    half;
    flush = 1'b0; fpu_ready = 1'b0;
    drive(1'b0, '0, '0, '0);
    tests_run++;
    if (count !== 3'd0 || enable !== 1'b0) begin
      failures++; $display("FAIL flush_clear count=%0d en=%b required 0/0", count, enable);
    end
  endtask

  task automatic test_reset_mid;
    half; drive(1'b1, FADD, 4'd1, 32'h1);
    half; drive(1'b1, FADD, 4'd2, 32'h2);
    #2;
    rst = 1'b0;
    #1;
    tests_run++;
    if (enable !== 1'b0 || count !== 3'd0) begin
      failures++; $display("FAIL reset_mid en=%b count=%0d required 0/0", enable, count);
    end
    drive(1'b0, '0, '0, '0);
    @(negedge ck); rst = 1'b1;
  endtask

  task automatic test_bypass;
    half;
    fpu_ready = 1'b1;
    drive(1'b1, 32'h10C58553, 4'd9, 32'h99);
    #1;
`ifdef RVFPM_ISSUE_BYPASS_EN
    tests_run++;
    if (enable !== 1'b1 || id !== 4'd9 || instruction !== 32'h10C58553) begin
      failures++; $display("FAIL bypass_same en=%b id=%0d instr=%h required 1/9/10c58553", enable, id, instruction);
    end
    half;
    drive(1'b0, '0, '0, '0);
    fpu_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0 || enable !== 1'b0) begin
      failures++; $display("FAIL bypass_nostore count=%0d en=%b required 0/0", count, enable);
    end
`else
    tests_run++;
    if (enable !== 1'b0 || id !== 4'd0) begin
      failures++; $display("FAIL nobypass_same en=%b id=%0d required 0/0", enable, id);
    end
    half;
    drive(1'b0, '0, '0, '0);
    tests_run++;
    if (count !== 3'd1 || id !== 4'd9 || data_fromXReg !== 32'h99) begin
      failures++; $display("FAIL nobypass_stored count=%0d id=%0d rs1=%h required 1/9/99", count, id, data_fromXReg);
    end
    half;
    fpu_ready = 1'b0;
    tests_run++;
    if (count !== 3'd0) begin
      failures++; $display("FAIL nobypass_drain count=%0d required 0", count);
    end
`endif
  endtask

  initial begin
    test_reset;
    test_single;
    test_non_fp;
    test_full;
    test_back_to_back;
    test_wrap;
    test_flush;
    test_reset_mid;
    test_bypass;
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout simulation exceeded 20000 time units");
    $fatal(1);
  end

endmodule
